subtrator_serial: RTL and testbench



---
 rtl/subtrator_serial.sv | 163 ++++++++++++++++
 tb/tb_subtrator_serial.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/subtrator_serial.sv
// -----------------------------------------------------------------------------
// subtrator_serial
//   Bit-serial subtractor: computes diferenca = a - b over WIDTH clock cycles,
//   one bit per cycle, LSB first. It uses a single full-subtractor cell, which
//   is the subtracting counterpart of the 3-input full-adder cell.
//
//   Ports
//     clk        : system clock, rising edge active
//     rst_n      : asynchronous active-low reset
//     start      : request, accepted only while not busy (IDLE or DONE)
//     a, b       : minuend / subtrahend, captured on the accepting edge only
//     busy       : high while operand bits are being processed
//     done       : one-cycle pulse, result outputs valid
//     diferenca  : a - b mod 2^WIDTH, held until the next completion
//     borrow_out : final borrow, 1 iff unsigned a < b
//     overflow   : two's complement overflow of a - b
// -----------------------------------------------------------------------------
module subtrator_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diferenca,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_next, difference_bit}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bw);
        logic d;
        logic bn;
        d  = x ^ y ^ bw;
        bn = (~x & y) | (~(x ^ y) & bw);
        return {bn, d};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] reg_a_r;
    logic [WIDTH-1:0] reg_b_r;
    logic [WIDTH-1:0] res_r;
    logic [CW-1:0]    cnt_r;
    logic             bw_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diferenca_r;
    logic             borrow_out_r;
    logic             overflow_r;

    logic             x_s;
    logic             y_s;
    logic [1:0]       cell_s;
    logic             d_s;
    logic             bw_next_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_s;

    assign x_s        = reg_a_r[0];
    assign y_s        = reg_b_r[0];
    assign cell_s     = full_sub(x_s, y_s, bw_r);
    assign d_s        = cell_s[0];
    assign bw_next_s  = cell_s[1];
    // New difference bit enters at the MSB so that after WIDTH shifts the
    // first (LSB) bit has reached position 0.
    assign res_next_s = {d_s, res_r[WIDTH-1:1]};
    assign last_s     = (cnt_r == CW'(WIDTH - 1));

    // Control FSM, datapath shift registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            reg_a_r      <= {WIDTH{1'b0}};
            reg_b_r      <= {WIDTH{1'b0}};
            res_r        <= {WIDTH{1'b0}};
            cnt_r        <= {CW{1'b0}};
            bw_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            diferenca_r  <= {WIDTH{1'b0}};
            borrow_out_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        reg_a_r <= a;
                        reg_b_r <= b;
                        res_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        bw_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    reg_a_r <= reg_a_r >> 1;
                    reg_b_r <= reg_b_r >> 1;
                    res_r   <= res_next_s;
                    bw_r    <= bw_next_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        // x, y and d here belong to the MSB, which is what
                        // the signed overflow rule needs.
                        diferenca_r  <= res_next_s;
                        borrow_out_r <= bw_next_s;
                        overflow_r   <= (x_s != y_s) && (d_s != x_s);
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Back-to-back request: no IDLE cycle in between.
                        reg_a_r <= a;
                        reg_b_r <= b;
                        res_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        bw_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign diferenca  = diferenca_r;
    assign borrow_out = borrow_out_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_subtrator_serial.sv
// -----------------------------------------------------------------------------
// tb_subtrator_serial
//   Scoreboard bench for subtrator_serial. Two instances share clock and
//   reset: an 8-bit one for directed/random/handshake cases and a 4-bit one
//   swept over every operand pair. Expected results come from an arithmetic
//   reference model and are queued at issue time; monitor processes pop and
//   compare whenever a done pulse appears.
// -----------------------------------------------------------------------------
module tb_subtrator_serial;

    typedef struct {
        logic [31:0] diff;
        logic        bo;
        logic        ov;
    } exp_t;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bo8;
    logic       ov8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bo4;
    logic       ov4;

    int   checks;
    int   errors;
    exp_t q8[$];
    exp_t q4[$];
    logic [7:0] last_diff8;

    subtrator_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diferenca(diff8),
        .borrow_out(bo8), .overflow(ov8)
    );

    subtrator_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diferenca(diff4),
        .borrow_out(bo4), .overflow(ov4)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed/unsigned arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input int unsigned a, input int unsigned b);
        exp_t   e;
        longint lim;
        longint sa;
        longint sb;
        longint s;
        lim    = longint'(1) << (w - 1);
        e.diff = 32'((longint'(a) - longint'(b)) & ((lim + lim) - longint'(1)));
        e.bo   = (a < b);
        sa     = (longint'(a) >= lim) ? longint'(a) - (lim + lim) : longint'(a);
        sb     = (longint'(b) >= lim) ? longint'(b) - (lim + lim) : longint'(b);
        s      = sa - sb;
        e.ov   = (s < -lim) || (s >= lim);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon8();
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_done8", 32'(done8), 32'(1'b0));
                end else begin
                    e = q8.pop_front();
                    chk("diff8", 32'(diff8), e.diff);
                    chk("borrow8", 32'(bo8), 32'(e.bo));
                    chk("ovf8", 32'(ov8), 32'(e.ov));
                end
                chk("done8_single_cycle", 32'(prev), 32'(1'b0));
            end
            prev = done8;
        end
    endtask

    task automatic mon4();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done4) begin
                if (q4.size() == 0) begin
                    chk("unexpected_done4", 32'(done4), 32'(1'b0));
                end else begin
                    e = q4.pop_front();
                    chk("diff4", 32'(diff4), e.diff);
                    chk("borrow4", 32'(bo4), 32'(e.bo));
                    chk("ovf4", 32'(ov4), 32'(e.ov));
                end
            end
        end
    endtask

    // Issue one 8-bit operation. With now=1 the start is driven in the current
    // (done) cycle for a back-to-back request. With noise=1, start pulses and
    // operand changes are injected mid-operation. Returns cycles from issue
    // until done is seen and the number of busy cycles.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit now,
                       input bit noise, output int lat, output int bcnt);
        exp_t e;
        if (!now) @(negedge clk);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        e      = model(8, a, b);
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        chk("busy_after_start", 32'(busy8), 32'(1'b1));
        lat  = 1;
        bcnt = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bcnt++;
            if (lat == 3) chk("diff8_held", 32'(diff8), 32'(last_diff8));
            if (noise && lat >= 2 && lat <= 4) begin
                start8 = 1'b1;
                a8     = 8'($urandom);
                b8     = 8'($urandom);
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start8 = 1'b0;
        chk("done8_seen", 32'(done8), 32'(1'b1));
        last_diff8 = e.diff[7:0];
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        int n;
        @(negedge clk);
        start4 = 1'b1;
        a4     = a;
        b4     = b;
        q4.push_back(model(4, a, b));
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done4_seen", 32'(done4), 32'(1'b1));
    endtask

    initial begin
        int lat;
        int bcnt;
        int seen;
        checks     = 0;
        errors     = 0;
        last_diff8 = 8'h00;
        rst_n  = 1'b0;
        start8 = 1'b0;
        a8     = 8'h00;
        b8     = 8'h00;
        start4 = 1'b0;
        a4     = 4'h0;
        b4     = 4'h0;
        fork
            mon8();
            mon4();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'(1'b0));
        chk("rst_done", 32'(done8), 32'(1'b0));
        chk("rst_diff", 32'(diff8), 32'd0);
        chk("rst_borrow", 32'(bo8), 32'(1'b0));
        chk("rst_ovf", 32'(ov8), 32'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, including latency and busy length.
        op8(8'h05, 8'h03, 1'b0, 1'b0, lat, bcnt);
        chk("latency", 32'(lat), 32'd9);
        chk("busy_cycles", 32'(bcnt), 32'd8);
        op8(8'h03, 8'h05, 1'b0, 1'b0, lat, bcnt);
        op8(8'h80, 8'h01, 1'b0, 1'b0, lat, bcnt);
        op8(8'h7F, 8'hFF, 1'b0, 1'b0, lat, bcnt);

        // Back-to-back from the done cycle, with noise mid-operation.
        op8(8'hFF, 8'hFF, 1'b1, 1'b1, lat, bcnt);
        chk("b2b_period", 32'(lat), 32'd9);
        op8(8'($urandom), 8'($urandom), 1'b1, 1'b1, lat, bcnt);
        chk("b2b_period2", 32'(lat), 32'd9);

        // Random operands, occasionally noisy.
        for (int i = 0; i < 20; i++) begin
            op8(8'($urandom), 8'($urandom), 1'b0, 1'($urandom_range(0, 1)), lat, bcnt);
        end

        // Abort by reset in the middle of an operation.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h3C;
        b8     = 8'h11;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy8), 32'(1'b0));
        chk("abort_done", 32'(done8), 32'(1'b0));
        chk("abort_diff", 32'(diff8), 32'd0);
        chk("abort_borrow", 32'(bo8), 32'(1'b0));
        chk("abort_ovf", 32'(ov8), 32'(1'b0));
        last_diff8 = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        op8(8'h10, 8'h20, 1'b0, 1'b0, lat, bcnt);

        // Exhaustive 4-bit sweep.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                op4(4'(i), 4'(j));
            end
        end

        repeat (2) @(negedge clk);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
